// File: rtl/pit_table.sv
// Pending-interest table: matches returning data packets against stored interest
// prefixes, buffers a hit's payload and replays it as a header plus byte stream.
module pit_table #(
  parameter int ENTRIES    = 4,
  parameter int DATA_BYTES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SPI_to_PIT_bit,
  input  logic [5:0]  SPI_to_PIT_length,
  input  logic [63:0] SPI_to_PIT_prefix,
  input  logic        data_start,
  input  logic [63:0] data_prefix,
  input  logic        data_byte_valid,
  input  logic [7:0]  data_byte,
  output logic [63:0] PIT_to_SPI_prefix,
  output logic        PIT_to_SPI_start,
  output logic [7:0]  PIT_to_SPI_data,
  output logic        PIT_to_SPI_data_valid,
  output logic        busy,
  output logic        pit_full_drop,
  output logic        data_drop
);

  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CAPTURE   = 3'd1,
    DISCARD   = 3'd2,
    SEND_HDR  = 3'd3,
    SEND_DATA = 3'd4
  } state_t;

  logic [ENTRIES-1:0] valid_r;
  logic [5:0]         len_r [ENTRIES];
  logic [63:0]        pfx_r [ENTRIES];
  logic [7:0]         buf_r [DATA_BYTES];

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [63:0]   lat_pfx_r, out_pfx_r;
  logic          start_r, start_s;
  logic          dv_r, dv_s;
  logic [7:0]    data_r, data_s;
  logic          drop_r, drop_s;
  logic          busy_r;
  logic          full_drop_r;
  logic          clr_s;

  logic          ins_hit_s, free_s, dat_hit_s;
  logic [IW-1:0] ins_idx_s, free_idx_s, dat_idx_s;

  assign PIT_to_SPI_prefix     = out_pfx_r;
  assign PIT_to_SPI_start      = start_r;
  assign PIT_to_SPI_data       = data_r;
  assign PIT_to_SPI_data_valid = dv_r;
  assign busy                  = busy_r;
  assign pit_full_drop         = full_drop_r;
  assign data_drop             = drop_r;

  // Table lookups; descending scan so the lowest index wins
  always_comb begin
    ins_hit_s  = 1'b0;
    ins_idx_s  = {IW{1'b0}};
    free_s     = 1'b0;
    free_idx_s = {IW{1'b0}};
    dat_hit_s  = 1'b0;
    dat_idx_s  = {IW{1'b0}};
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      ins_hit_s  = ins_hit_s | (valid_r[i] & (pfx_r[i] == SPI_to_PIT_prefix));
      ins_idx_s  = (valid_r[i] && (pfx_r[i] == SPI_to_PIT_prefix)) ? IW'(i) : ins_idx_s;
      free_s     = free_s | ~valid_r[i];
      free_idx_s = (!valid_r[i]) ? IW'(i) : free_idx_s;
      dat_hit_s  = dat_hit_s | (valid_r[i] & (pfx_r[i] == data_prefix));
      dat_idx_s  = (valid_r[i] && (pfx_r[i] == data_prefix)) ? IW'(i) : dat_idx_s;
    end
  end

  // Data FSM next state and next registered outputs
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    start_s = 1'b0;
    dv_s    = 1'b0;
    data_s  = 8'h00;
    drop_s  = 1'b0;
    clr_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (data_start) begin
          if (dat_hit_s) begin
            state_s = CAPTURE;
            clr_s   = 1'b1;
          end else begin
            state_s = DISCARD;
            drop_s  = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CAPTURE, DISCARD: begin
        drop_s = data_start;
        if (data_byte_valid) begin
          if (cnt_r == LAST_CNT) begin
            cnt_s   = {CW{1'b0}};
            state_s = (state_r == CAPTURE) ? SEND_HDR : IDLE;
            start_s = (state_r == CAPTURE);
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      SEND_HDR: begin
        drop_s  = data_start;
        state_s = SEND_DATA;
        cnt_s   = {CW{1'b0}};
        dv_s    = 1'b1;
        data_s  = buf_r[0];
      end
      SEND_DATA: begin
        drop_s = data_start;
        if (cnt_r == LAST_CNT) begin
          state_s = IDLE;
          cnt_s   = {CW{1'b0}};
        end else begin
          dv_s   = 1'b1;
          data_s = buf_r[cnt_r + CW'(1)];
          cnt_s  = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // Interest table; the hit clear comes first so a same-cycle insert can reinstall it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r     <= {ENTRIES{1'b0}};
      full_drop_r <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        len_r[i] <= 6'd0;
        pfx_r[i] <= 64'd0;
      end
    end else begin
      full_drop_r <= SPI_to_PIT_bit & ~ins_hit_s & ~free_s;
      if (clr_s) valid_r[dat_idx_s] <= 1'b0;
      if (SPI_to_PIT_bit) begin
        if (ins_hit_s) begin
          valid_r[ins_idx_s] <= 1'b1;
          if (len_r[ins_idx_s] != SPI_to_PIT_length) len_r[ins_idx_s] <= SPI_to_PIT_length;
        end else if (free_s) begin
          valid_r[free_idx_s] <= 1'b1;
          len_r[free_idx_s]   <= SPI_to_PIT_length;
          pfx_r[free_idx_s]   <= SPI_to_PIT_prefix;
        end
      end
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      lat_pfx_r <= 64'd0;
      out_pfx_r <= 64'd0;
      start_r   <= 1'b0;
      dv_r      <= 1'b0;
      data_r    <= 8'h00;
      drop_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      start_r <= start_s;
      dv_r    <= dv_s;
      data_r  <= data_s;
      drop_r  <= drop_s;
      busy_r  <= (state_s != IDLE);
      if (clr_s) lat_pfx_r <= data_prefix;
      if (start_s) out_pfx_r <= lat_pfx_r;
    end
  end

  // Payload buffer
  always_ff @(posedge clk) begin
    if ((state_r == CAPTURE) && data_byte_valid) buf_r[cnt_r] <= data_byte;
  end

endmodule

// File: tb/tb_pit_table.sv
// Scoreboard bench for pit_table: stimulus queues expected headers/bytes,
// a negedge monitor pops and compares whatever the DUT emits.
module tb_pit_table;
  localparam int NB = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        SPI_to_PIT_bit;
  logic [5:0]  SPI_to_PIT_length;
  logic [63:0] SPI_to_PIT_prefix;
  logic        data_start;
  logic [63:0] data_prefix;
  logic        data_byte_valid;
  logic [7:0]  data_byte;
  logic [63:0] PIT_to_SPI_prefix;
  logic        PIT_to_SPI_start;
  logic [7:0]  PIT_to_SPI_data;
  logic        PIT_to_SPI_data_valid;
  logic        busy;
  logic        pit_full_drop;
  logic        data_drop;

  int total = 0, bad = 0;
  int full_cnt = 0, drop_cnt = 0, total_beats = 0, beats = 0;
  bit in_pkt = 1'b0;
  logic [63:0] hdr_q[$];
  logic [7:0]  byte_q[$];

  always #5 clk = ~clk;

  pit_table #(.ENTRIES(4), .DATA_BYTES(NB)) dut (
    .clk(clk), .rst(rst),
    .SPI_to_PIT_bit(SPI_to_PIT_bit), .SPI_to_PIT_length(SPI_to_PIT_length),
    .SPI_to_PIT_prefix(SPI_to_PIT_prefix), .data_start(data_start),
    .data_prefix(data_prefix), .data_byte_valid(data_byte_valid), .data_byte(data_byte),
    .PIT_to_SPI_prefix(PIT_to_SPI_prefix), .PIT_to_SPI_start(PIT_to_SPI_start),
    .PIT_to_SPI_data(PIT_to_SPI_data), .PIT_to_SPI_data_valid(PIT_to_SPI_data_valid),
    .busy(busy), .pit_full_drop(pit_full_drop), .data_drop(data_drop)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // Monitor: header and byte stream against the scoreboard queues
  always @(negedge clk) begin
    if (!rst) begin
      in_pkt = 1'b0;
    end else begin
      if (pit_full_drop) full_cnt++;
      if (data_drop) drop_cnt++;
      if (PIT_to_SPI_start) begin
        if (in_pkt) flag("start_inside_packet");
        if (hdr_q.size() == 0) flag("unexpected_start");
        else check("hdr_prefix", PIT_to_SPI_prefix, hdr_q.pop_front());
        in_pkt = 1'b1;
        beats  = 0;
      end else if (in_pkt) begin
        if (!PIT_to_SPI_data_valid) begin
          flag("beat_gap");
          in_pkt = 1'b0;
        end else begin
          if (byte_q.size() == 0) flag("unexpected_byte");
          else check("byte", 64'(PIT_to_SPI_data), 64'(byte_q.pop_front()));
          beats++;
          total_beats++;
          if (beats == NB) in_pkt = 1'b0;
        end
      end else if (PIT_to_SPI_data_valid) begin
        flag("stray_beat");
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic interest(input logic [63:0] p, input logic [5:0] l, input logic exp_full);
    SPI_to_PIT_bit    = 1'b1;
    SPI_to_PIT_prefix = p;
    SPI_to_PIT_length = l;
    tick();
    SPI_to_PIT_bit = 1'b0;
    check("pit_full_drop", 64'(pit_full_drop), 64'(exp_full));
  endtask

  task automatic send_data(input logic [63:0] p, input logic [7:0] base, input bit gap,
                           input bit hit, input bit ins_en, input logic [63:0] ins_p);
    if (hit) begin
      hdr_q.push_back(p);
      for (int i = 0; i < NB; i++) byte_q.push_back(base + 8'(i));
    end
    data_start        = 1'b1;
    data_prefix       = p;
    SPI_to_PIT_bit    = ins_en;
    SPI_to_PIT_prefix = ins_p;
    SPI_to_PIT_length = 6'd8;
    tick();
    data_start     = 1'b0;
    SPI_to_PIT_bit = 1'b0;
    check("data_drop", 64'(data_drop), 64'(!hit));
    check("busy_after_start", 64'(busy), 64'd1);
    for (int i = 0; i < NB; i++) begin
      data_byte_valid = 1'b1;
      data_byte       = base + 8'(i);
      tick();
      if (i == NB - 1) begin
        check("start_latency", 64'(PIT_to_SPI_start), 64'(hit));
      end else if (gap) begin
        data_byte_valid = 1'b0;
        data_byte       = 8'hEE;
        tick();
      end
    end
    data_byte_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    if (busy) flag("idle_timeout");
    tick();
  endtask

  localparam logic [63:0] A = 64'hA5A5_0000_0000_0001;
  localparam logic [63:0] X = 64'h0000_0000_CAFE_0000;
  localparam logic [63:0] G = 64'h00C0_FFEE_0000_0001;
  localparam logic [63:0] G2 = 64'h00C0_FFEE_0000_0002;
  localparam logic [63:0] S = 64'h5555_0000_AAAA_0001;
  localparam logic [63:0] U = 64'h7777_0000_0000_0003;
  localparam logic [63:0] V = 64'h8888_0000_0000_0004;
  localparam logic [63:0] R = 64'hFEED_FACE_0000_0010;

  initial begin
    int d0, b0, n;
    rst = 1'b0;
    SPI_to_PIT_bit = 1'b0; SPI_to_PIT_length = 6'd0; SPI_to_PIT_prefix = 64'd0;
    data_start = 1'b0; data_prefix = 64'd0; data_byte_valid = 1'b0; data_byte = 8'h00;
    #23;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_start", 64'(PIT_to_SPI_start), 64'd0);
    check("rst_dv", 64'(PIT_to_SPI_data_valid), 64'd0);
    check("rst_prefix", PIT_to_SPI_prefix, 64'd0);
    check("rst_drops", 64'({pit_full_drop, data_drop}), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // Basic hit, then the consumed entry must miss
    interest(A, 6'd16, 1'b0);
    send_data(A, 8'h00, 1'b0, 1'b1, 1'b0, 64'd0);
    wait_idle();
    check("prefix_held", PIT_to_SPI_prefix, A);
    send_data(A, 8'h55, 1'b0, 1'b0, 1'b0, 64'd0);
    wait_idle();

    // Fill the table, overflow, aggregate
    for (int k = 0; k < 4; k++) interest(64'h100 + 64'(k), 6'd4, 1'b0);
    interest(64'h104, 6'd4, 1'b1);
    interest(64'h100, 6'd9, 1'b0);
    send_data(64'h104, 8'h77, 1'b0, 1'b0, 1'b0, 64'd0);
    wait_idle();
    interest(64'h104, 6'd4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      send_data(64'h100 + 64'(k), 8'(16 * k + 3), 1'b0, 1'b1, 1'b0, 64'd0);
      wait_idle();
    end
    check("full_cnt", 64'(full_cnt), 64'd2);

    // Unknown prefix is discarded and leaves the table alone
    interest(X, 6'd12, 1'b0);
    d0 = drop_cnt;
    send_data(64'h1234, 8'h01, 1'b0, 1'b0, 1'b0, 64'd0);
    wait_idle();
    check("miss_drop_cnt", 64'(drop_cnt - d0), 64'd1);
    send_data(X, 8'hC0, 1'b0, 1'b1, 1'b0, 64'd0);
    wait_idle();

    // Gapped payload; data_start while busy is dropped without consuming G2
    interest(G, 6'd5, 1'b0);
    interest(G2, 6'd5, 1'b0);
    send_data(G, 8'hA0, 1'b1, 1'b1, 1'b0, 64'd0);
    data_start = 1'b1;
    data_prefix = G2;
    tick();
    data_start = 1'b0;
    check("busy_drop", 64'(data_drop), 64'd1);
    wait_idle();
    send_data(G2, 8'h60, 1'b0, 1'b1, 1'b0, 64'd0);
    wait_idle();

    // Same-cycle insert and hit: same prefix, then different prefixes
    interest(S, 6'd7, 1'b0);
    send_data(S, 8'h30, 1'b0, 1'b1, 1'b1, S);
    wait_idle();
    send_data(S, 8'h70, 1'b0, 1'b1, 1'b0, 64'd0);
    wait_idle();
    interest(U, 6'd7, 1'b0);
    send_data(U, 8'h90, 1'b0, 1'b1, 1'b1, V);
    wait_idle();
    send_data(V, 8'hE0, 1'b0, 1'b1, 1'b0, 64'd0);
    wait_idle();

    // Reset in the middle of the output stream
    interest(R, 6'd3, 1'b0);
    b0 = total_beats;
    send_data(R, 8'h20, 1'b0, 1'b1, 1'b0, 64'd0);
    n = 0;
    while (total_beats < b0 + 11 && n < 100) begin
      tick();
      n++;
    end
    if (total_beats < b0 + 11) flag("reset_wait_timeout");
    rst = 1'b0;
    #1;
    check("mid_rst_dv", 64'(PIT_to_SPI_data_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_prefix", PIT_to_SPI_prefix, 64'd0);
    hdr_q.delete();
    byte_q.delete();
    tick();
    tick();
    rst = 1'b1;
    tick();
    send_data(R, 8'h11, 1'b0, 1'b0, 1'b0, 64'd0);
    wait_idle();
    interest(R, 6'd3, 1'b0);
    send_data(R, 8'hB0, 1'b0, 1'b1, 1'b0, 64'd0);
    wait_idle();

    check("hdr_q_empty", 64'(hdr_q.size()), 64'd0);
    check("byte_q_empty", 64'(byte_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
